nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder controller that time-multiplexes one 4-bit ripple carry adder slice across the operand, least-significant nibble first. It carries the inter-nibble carry in a register and exposes valid/ready handshakes on both input and output. It sits between an operand producer and a result consumer wherever a wide add is needed but area forbids a full-width adder.

## Interface
- WIDTH, 16: operand width in bits; multiple of 4, minimum 8. NIB = WIDTH/4.
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- op_sub  input  1  subtract (A − B); present only with SUB_EN.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carry  output  1  carry out of bit WIDTH−1.
- ovf  output  1  signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1 at an edge, register a and b, load carry_reg=cin, and clear the nibble index idx to 0. Go to RUN.
- RUN: slice inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg. Each edge:
  - writes the slice sum into sum[4*idx+:4];
  - loads the slice cout into carry_reg;
  - increments idx.
- Exit RUN: on the edge where idx==NIB−1, additionally:
  - set carry = slice cout;
  - set ovf = (carry into the MSB) XOR cout, where carry into the MSB = a3^b3^s3 of the final nibble, using the effective (possibly inverted) B;
  - go to DONE.
- DONE: out_valid=1. sum, carry and ovf are stable. On out_ready=1 at an edge, go to IDLE.
- Inputs a, b, cin and op_sub are sampled only at the accepting edge. Later changes have no effect.
- in_valid during RUN or DONE is ignored; it is not queued.
- sum holds partial values during RUN and is defined only while out_valid=1. Outputs keep the last result in IDLE until the next accept.
- Arithmetic is modulo 2^WIDTH. carry is the unsigned carry. ovf is two's-complement overflow.

## Timing
- Reset values after a reset edge: state IDLE, in_ready=1, out_valid=0, sum=0, carry=0, ovf=0, idx=0, carry_reg=0.
- Reset mid-RUN or in DONE: the operation is abandoned, no out_valid is produced, and in_ready=1 after the reset edge.
- Latency: operands accepted at edge k give out_valid=1 after edge k+NIB. For WIDTH=16 that is 4 cycles.
- Maximum throughput: one operation per NIB+2 cycles (IDLE cycle + NIB RUN cycles + ≥1 DONE cycle).
- Backpressure: out_valid is held with no upper bound while out_ready=0.
- out_ready=1 and in_valid=1 in the same DONE cycle: only the result handshake completes. New operands can be accepted no earlier than the following IDLE cycle.
- Carry propagation: the worst case is a single slice delay per cycle. There is no combinational path from any input to any output; all outputs are registered or are a decode of state.

## Configuration
- SUB_EN defined:
  - the op_sub port exists;
  - when op_sub=1 at accept, b_reg is loaded with ~b and carry_reg with 1, and cin is ignored;
  - carry=1 means no borrow;
  - ovf is computed on the effective operands.
- SUB_EN undefined:
  - the op_sub port is absent;
  - b_reg=b and carry_reg=cin;
  - no inversion logic is present.

## Structure
- Shared package holds the state enum (IDLE, RUN, DONE) and localparam NIB_W=4.
- One sub-module: the existing 4-bit ripple_carry_adder (full-adder chain), instantiated once as the slice. The controller owns all registers, the index and the nibble mux/demux.
- idx width is $clog2(NIB), with a minimum of 1.

## Test plan
- Reset: assert rst for 2 cycles, release -> in_ready=1, out_valid=0, sum=0x0000, carry=0, ovf=0.
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, carry=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1, ovf=0. With cin=1, a=0xFFFF, b=0x0000 -> sum=0x0000, carry=1.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, carry=0, ovf=1.
- Backpressure and ignored requests: hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid with other operands -> out_valid stays 1, sum stays stable, in_ready=0, no second result. Then out_ready=1 -> IDLE the next cycle.
- SUB_EN and reset mid-run:
  - op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, carry=0.
  - rst during the 2nd RUN cycle -> out_valid never asserts, in_ready=1 after the reset edge.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding
// and the slice width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder slice built from a chain of full adders; the
// controller reuses this one slice for every nibble of the operands.
module ripple_carry_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one 4-bit slice across the operands, LS nibble
// first, with valid/ready on both sides. Define SUB_EN to add the op_sub port.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [NIB_W-1:0]   sum_nib_reg [NIB];
  logic               carry_out_reg;
  logic               ovf_reg;

  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [NIB_W-1:0]   a_nib [NIB];
  logic [NIB_W-1:0]   b_nib [NIB];
  logic [NIB_W-1:0]   slice_a, slice_b, slice_s;
  logic               slice_cout;
  logic               last_nib;
  logic               msb_cin;

`ifdef SUB_EN
  // Subtraction is A + ~B + 1, so the incoming carry is forced high.
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign a_nib[gi]                  = a_reg[gi*NIB_W +: NIB_W];
    assign b_nib[gi]                  = b_reg[gi*NIB_W +: NIB_W];
    assign sum[gi*NIB_W +: NIB_W]     = sum_nib_reg[gi];
  end

  assign slice_a  = a_nib[idx_reg];
  assign slice_b  = b_nib[idx_reg];
  assign last_nib = (idx_reg == IDX_W'(NIB - 1));

  ripple_carry_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Carry into bit 3 of the slice recovered from the sum bit.
  assign msb_cin = slice_a[NIB_W-1] ^ slice_b[NIB_W-1] ^ slice_s[NIB_W-1];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      carry_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      for (int i = 0; i < NIB; i++) sum_nib_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= cin_eff;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_nib_reg[idx_reg] <= slice_s;
          carry_reg            <= slice_cout;
          idx_reg              <= idx_reg + IDX_W'(1);
          if (last_nib) begin
            carry_out_reg <= slice_cout;
            ovf_reg       <= msb_cin ^ slice_cout;
            idx_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign carry = carry_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed table, random ops
// against an arithmetic model, backpressure and reset-mid-run sequences.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         op_sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         carry, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide addition on the effective operands.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sub);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    logic         o;
    yy   = sub ? ~y : y;
    cc   = sub ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    o    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {o, full};
  endfunction

  task automatic wait_out_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic xs, output logic [W-1:0] rs, output logic rc,
                        output logic ro, output int lat);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; cin = xc; op_sub = xs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
    wait_out_valid(lat);
    rs = sum; rc = carry; ro = ovf;
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h carry=%0d ovf=%0d lat=%0d",
             xa, xb, xc, xs, rs, rc, ro, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_ack", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rs, held;
    logic         rc, ro, sub;
    logic [W+1:0] m;
    int           lat, hits;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("vec%0d_carry", i), 32'(rc), 32'(vecs[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].o));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIB));
    end

`ifdef SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
    chk("sub_sum", 32'(rs), 32'hFFFE);
    chk("sub_carry", 32'(rc), 32'd0);
    chk("sub_ovf", 32'(ro), 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rci;
      ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
`ifdef SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      m = ref_add(ra, rb, rci, sub);
      run_op(ra, rb, rci, sub, rs, rc, ro, lat);
      chk($sformatf("rnd%0d_sum", i), 32'(rs), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d_carry", i), 32'(rc), 32'(m[W]));
      chk($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(m[W+1]));
    end

    // Backpressure with ignored requests while the result is held.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_latency", 32'(lat), 32'(NIB));
    chk("bp_sum", 32'(sum), 32'h3333);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_sum_stable", i), 32'(sum), 32'(held));
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    hits = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) hits++;
    end
    chk("bp_no_second_result", 32'(hits), 32'd0);

    // Reset during the second RUN cycle abandons the operation.
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'h0);
    hits = 0;
    for (int i = 0; i < NIB + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) hits++;
    end
    chk("midrst_no_result", 32'(hits), 32'd0);

    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_rst_sum", 32'(rs), 32'h1000);
    chk("post_rst_latency", 32'(lat), 32'(NIB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
